// File: rtl/pipelined_mem.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_mem
// Purpose  : Single-port word memory with per-byte write enables and a fully
//            pipelined read path of configurable latency. Out-of-range reads
//            return zero with an error flag. Out-of-range writes are dropped.
//            The same-cycle read/write collision policy is selectable.
// Ports    : clk        - clock, rising edge
//            rst        - asynchronous, active-low reset
//            WE / RE    - write / read request
//            Address    - word address shared by read and write
//            Data_in    - write data
//            Byte_en    - per-byte write enable (bit i -> Data_in[8i+7:8i])
//            Data_out   - read data, held between results
//            valid_out  - Data_out carries a read result this cycle
//            err_out    - that result came from an out-of-range address
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int MEM_DEPTH  = 16,
  parameter int RD_LATENCY = 1,
  parameter int WRITE_MODE = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    WE,
  input  logic                    RE,
  input  logic [ADDR_WIDTH-1:0]   Address,
  input  logic [DATA_WIDTH-1:0]   Data_in,
  input  logic [DATA_WIDTH/8-1:0] Byte_en,
  output logic [DATA_WIDTH-1:0]   Data_out,
  output logic                    valid_out,
  output logic                    err_out
);

  localparam int                c_NBYTES = DATA_WIDTH / 8;
  // One extra bit so the depth itself is representable when it equals 2^ADDR_WIDTH.
  localparam logic [ADDR_WIDTH:0] c_DEPTH = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic                  w_in_range;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic [DATA_WIDTH-1:0] w_merged;
  logic [DATA_WIDTH-1:0] w_rd_data;

  logic                  r_vld [RD_LATENCY];
  logic                  r_err [RD_LATENCY];
  logic [DATA_WIDTH-1:0] r_dat [RD_LATENCY];

  assign w_in_range = ({1'b0, Address} < c_DEPTH);
  assign w_rd_word  = w_in_range ? r_mem[Address] : '0;

  // Current word with the enabled bytes replaced; this is both the value
  // written back and the write-first read result.
  generate
    for (genvar b = 0; b < c_NBYTES; b++) begin : g_byte
      assign w_merged[8*b +: 8] = Byte_en[b] ? Data_in[8*b +: 8] : w_rd_word[8*b +: 8];
    end
  endgenerate

  // Address is shared, so WE && RE always means a same-address collision.
  always_comb begin
    w_rd_data = '0;
    if (w_in_range) begin
      if ((WRITE_MODE == 1) && WE) begin
        w_rd_data = w_merged;
      end else begin
        w_rd_data = w_rd_word;
      end
    end
  end

  // With Byte_en all zero the merged word equals the stored word, so the
  // write leaves memory unchanged without a special case.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (WE && w_in_range) begin
      r_mem[Address] <= w_merged;
    end
  end

  // Read pipeline head. Data/err only load with a valid read so the last
  // stage keeps the most recent result while no new result arrives.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld[0] <= 1'b0;
      r_err[0] <= 1'b0;
      r_dat[0] <= '0;
    end else begin
      r_vld[0] <= RE;
      if (RE) begin
        r_err[0] <= !w_in_range;
        r_dat[0] <= w_rd_data;
      end
    end
  end

  generate
    for (genvar k = 1; k < RD_LATENCY; k++) begin : g_stage
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_vld[k] <= 1'b0;
          r_err[k] <= 1'b0;
          r_dat[k] <= '0;
        end else begin
          r_vld[k] <= r_vld[k-1];
          if (r_vld[k-1]) begin
            r_err[k] <= r_err[k-1];
            r_dat[k] <= r_dat[k-1];
          end
        end
      end
    end
  endgenerate

  assign valid_out = r_vld[RD_LATENCY-1];
  assign err_out   = r_vld[RD_LATENCY-1] & r_err[RD_LATENCY-1];
  assign Data_out  = r_dat[RD_LATENCY-1];

endmodule
`default_nettype wire

// File: doc/pipelined_mem.md
PIPELINED_MEM -- requirements
Module: pipelined_mem

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning the word width in bits, a multiple of 8.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 4, meaning the address width in bits.
REQ-003 The block SHALL have parameter MEM_DEPTH, default 16, meaning the number of words, with 1 <= MEM_DEPTH <= 2^ADDR_WIDTH.
REQ-004 The block SHALL have parameter RD_LATENCY, default 1, meaning the read latency in cycles, legal range 1..4.
REQ-005 The block SHALL have parameter WRITE_MODE, default 0, meaning same-address collision policy: 0 = read-first, 1 = write-first.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all logic samples on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-008 The block SHALL have port WE, input, 1 bit: write request.
REQ-009 The block SHALL have port RE, input, 1 bit: read request.
REQ-010 The block SHALL have port Address, input, ADDR_WIDTH bits: word address shared by read and write.
REQ-011 The block SHALL have port Data_in, input, DATA_WIDTH bits: write data.
REQ-012 The block SHALL have port Byte_en, input, DATA_WIDTH/8 bits: per-byte write enable; bit i gates Data_in[8i+7:8i].
REQ-013 The block SHALL have port Data_out, output, DATA_WIDTH bits: read data.
REQ-014 The block SHALL have port valid_out, output, 1 bit: Data_out carries a read result this cycle.
REQ-015 The block SHALL have port err_out, output, 1 bit: the read result accompanying valid_out was out of range.

Function
REQ-016 A write SHALL occur on a rising edge with WE=1 and Address<MEM_DEPTH, updating only bytes whose Byte_en bit is 1.
REQ-017 A write with Byte_en all zero SHALL leave memory unchanged.
REQ-018 A write with Address>=MEM_DEPTH SHALL be ignored: no memory change and no flag.
REQ-019 A read accepted at edge N (RE=1) SHALL produce valid_out=1 with its data at edge N+RD_LATENCY, for exactly one cycle.
REQ-020 Reads SHALL be fully pipelined: one read accepted per cycle with no stalls, and results returned in issue order.
REQ-021 A read with Address>=MEM_DEPTH SHALL return Data_out=0 with err_out=1 at the same latency.
REQ-022 err_out SHALL be 0 whenever valid_out=0.
REQ-023 When WE=1 and RE=1 target the same in-range address in one cycle, WRITE_MODE=0 SHALL return the pre-write word and WRITE_MODE=1 SHALL return the byte-merged post-write word.
REQ-024 A read issued on the cycle after a write to the same address SHALL return the written data regardless of WRITE_MODE.
REQ-025 Data_out SHALL hold its last valid value while valid_out=0.
REQ-026 Pipeline state SHALL be a RD_LATENCY-deep shift register of {valid, err, data}, with no other state machine.
REQ-027 WE and RE SHALL be fully independent; neither blocks the other.

Reset
REQ-028 While rst=0, valid_out, err_out and Data_out SHALL be 0 immediately, without waiting for a clock edge.
REQ-029 While rst=0, all memory words SHALL clear to 0 and all pipeline stages SHALL clear.
REQ-030 Reads in flight when rst asserts SHALL be discarded and never produce valid_out after reset release.
REQ-031 The first edge with rst=1 SHALL accept requests normally.

Verification
REQ-032 Write 0xDEADBEEF to addr 3 with Byte_en=0xF, then read addr 3 (RD_LATENCY=1) -> valid_out=1 one cycle later, Data_out=0xDEADBEEF, err_out=0.
REQ-033 Over 0xDEADBEEF at addr 3, write 0x11223344 with Byte_en=0x5 -> read returns 0xDE22BE44.
REQ-034 Same-cycle WE=RE=1 at addr 7 holding 0xAAAA0000, Data_in=0x0000BBBB, Byte_en=0xF -> WRITE_MODE=0 returns 0xAAAA0000; WRITE_MODE=1 returns 0x0000BBBB.
REQ-035 MEM_DEPTH=12, ADDR_WIDTH=4: write 0x55 to addr 13, then read addr 13 -> Data_out=0, err_out=1; addrs 0..11 unchanged.
REQ-036 RD_LATENCY=3: read addrs 0,1,2 back-to-back, then assert rst=0 after the second result -> valid_out drops to 0 immediately, third result never appears, and a read of addr 0 after release returns 0.
REQ-037 RD_LATENCY=4: 8 consecutive reads of addrs 0..7 -> 8 consecutive valid_out pulses starting 4 cycles after the first read, data in issue order.
